// File: rtl/counter_pkg.sv
// Shared types and constants for the counter sweep controller slice.
package counter_pkg;

  localparam int unsigned WIDTH_DEF   = 4;
  localparam int unsigned DWELL_W_DEF = 8;
  localparam int unsigned SWEEP_W_DEF = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_UP,
    ST_DWELL_HI,
    ST_RUN_DOWN,
    ST_DWELL_LO,
    ST_DONE
  } sweep_state_t;

endpackage

// File: rtl/sweep_updown_counter.sv
// Loadable up/down counter datapath; load takes priority over count enable.
module sweep_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= (up_down == DIR_UP) ? count + 1'b1 : count - 1'b1;
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangular lo->hi->lo sweep sequencer with end-point dwell, tick pacing and sweep count.
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF,
  parameter int unsigned SWEEP_W = SWEEP_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               tick,
  input  logic [WIDTH-1:0]   lo_bound,
  input  logic [WIDTH-1:0]   hi_bound,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [SWEEP_W-1:0] num_sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               at_limit,
  output logic               sweep_done,
  output logic               done,
  output logic               cfg_err
);

  sweep_state_t state_q, state_d;

  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [DWELL_W-1:0] dwell_q, dwell_cnt_q;
  logic [SWEEP_W-1:0] num_q, sweep_cnt_q, sweep_inc;
  logic               dir_q, sweep_done_q, cfg_err_q;

  logic             idle_start, accept, reject;
  logic             at_lo, at_hi, step_en, dwell_exp, last_sweep;
  logic [WIDTH-1:0] count_inc, count_dec;

  sweep_updown_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .load_val(lo_bound),
    .en      (step_en),
    .up_down (state_q == ST_RUN_UP),
    .count   (count)
  );

  assign idle_start = (state_q == ST_IDLE) && start && !stop;
  assign accept     = idle_start && (lo_bound < hi_bound);
  assign reject     = idle_start && !(lo_bound < hi_bound);

  assign at_lo     = (count == lo_q);
  assign at_hi     = (count == hi_q);
  assign count_inc = count + 1'b1;
  assign count_dec = count - 1'b1;

  // Steps are never issued at a limit, so the counter cannot wrap.
  assign step_en = tick && !stop &&
                   (((state_q == ST_RUN_UP) && !at_hi) ||
                    ((state_q == ST_RUN_DOWN) && !at_lo));

  assign dwell_exp  = (dwell_cnt_q == '0);
  assign sweep_inc  = (sweep_cnt_q == '1) ? sweep_cnt_q : sweep_cnt_q + 1'b1;
  assign last_sweep = (num_q != '0) && (sweep_inc == num_q);

  always_comb begin
    state_d = state_q;
    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:     if (accept) state_d = ST_RUN_UP;
        ST_RUN_UP:   if (step_en && (count_inc == hi_q)) state_d = ST_DWELL_HI;
        ST_DWELL_HI: if (dwell_exp) state_d = ST_RUN_DOWN;
        ST_RUN_DOWN: if (step_en && (count_dec == lo_q)) state_d = ST_DWELL_LO;
        ST_DWELL_LO: if (dwell_exp) state_d = last_sweep ? ST_DONE : ST_RUN_UP;
        ST_DONE:     state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      dwell_q      <= '0;
      num_q        <= '0;
      dwell_cnt_q  <= '0;
      sweep_cnt_q  <= '0;
      dir_q        <= DIR_UP;
      sweep_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_done_q <= 1'b0;
      cfg_err_q    <= reject;

      if (accept) begin
        lo_q        <= lo_bound;
        hi_q        <= hi_bound;
        dwell_q     <= dwell_cycles;
        num_q       <= num_sweeps;
        sweep_cnt_q <= '0;
        dir_q       <= DIR_UP;
      end

      // Dwell counter reloads on entry so each limit lasts dwell_q+1 cycles.
      if ((state_d != state_q) &&
          ((state_d == ST_DWELL_HI) || (state_d == ST_DWELL_LO))) begin
        dwell_cnt_q <= dwell_q;
      end else if (((state_q == ST_DWELL_HI) || (state_q == ST_DWELL_LO)) && !dwell_exp) begin
        dwell_cnt_q <= dwell_cnt_q - 1'b1;
      end

      if ((state_q == ST_DWELL_HI) && (state_d == ST_RUN_DOWN)) begin
        dir_q <= DIR_DOWN;
      end

      if ((state_q == ST_DWELL_LO) && (state_d != ST_DWELL_LO) && (state_d != ST_IDLE)) begin
        sweep_done_q <= 1'b1;
        sweep_cnt_q  <= sweep_inc;
        if (state_d == ST_RUN_UP) dir_q <= DIR_UP;
      end
    end
  end

  assign dir        = dir_q;
  assign busy       = (state_q != ST_IDLE);
  assign at_limit   = busy && (at_lo || at_hi);
  assign sweep_done = sweep_done_q;
  assign done       = (state_q == ST_DONE);
  assign cfg_err    = cfg_err_q;

endmodule
